// File: rtl/uart_pkg.sv
// Shared state encoding and sizing helper for the UART packet bridge.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SEND  = 3'd4
  } bridge_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Loadable idle counter: tc_o marks the LIMIT-th consecutive enabled,
// uncleared cycle.
module uart_byte_timer #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == LAST);

  // Holding at LAST keeps the counter from wrapping if the caller lingers.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_packet_bridge.sv
// Collects UART bytes into an operand word, starts the operator, then streams
// the result back out. Define UART_PACKET_BRIDGE_CHECKSUM_EN for XOR checksums.
module uart_packet_bridge
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int RX_WIDTH       = 65,
  parameter int TX_WIDTH       = 38,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] rx_byte,
  input  logic                 rx_valid,
  output logic [DATA_SIZE-1:0] tx_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [RX_WIDTH-1:0]  op_word,
  output logic                 op_start,
  input  logic                 op_done,
  input  logic [TX_WIDTH-1:0]  op_result,
  output logic                 busy,
  output logic                 rx_drop,
  output logic                 frame_err,
  output logic [2:0]           state_dbg
);

  localparam int RX_COUNT = ceil_div(RX_WIDTH, DATA_SIZE);
  localparam int TX_COUNT = ceil_div(TX_WIDTH, DATA_SIZE);
  localparam int SH_W     = RX_COUNT * DATA_SIZE;
  localparam int TXP_W    = TX_COUNT * DATA_SIZE;
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
  localparam int RX_FRAME = RX_COUNT + 1;
  localparam int TX_FRAME = TX_COUNT + 1;
`else
  localparam int RX_FRAME = RX_COUNT;
  localparam int TX_FRAME = TX_COUNT;
`endif
  localparam int TX_W  = TX_FRAME * DATA_SIZE;
  localparam int RXC_W = $clog2(RX_FRAME + 1);
  localparam int TXC_W = $clog2(TX_FRAME + 1);

  bridge_state_e       state_q, state_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [RXC_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [RX_WIDTH-1:0] op_word_q, op_word_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic                rx_drop_q, rx_drop_d;
  logic                frame_err_q, frame_err_d;
  logic                timeout;
  logic [TXP_W-1:0]    tx_pad;
  logic [TX_W-1:0]     tx_load;

  // Result zero-extended on the left so the pad bits lead the first TX byte.
  assign tx_pad = TXP_W'(op_result);

`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
  logic [DATA_SIZE-1:0] csum_q, csum_d;
  logic [DATA_SIZE-1:0] tx_sum;

  always_comb begin
    tx_sum = '0;
    for (int i = 0; i < TX_COUNT; i++) begin
      tx_sum = tx_sum ^ tx_pad[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  assign tx_load = {tx_pad, tx_sum};
`else
  assign tx_load = tx_pad;
`endif

  uart_byte_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(rx_valid || (state_q != ST_RECV)),
    .en_i   (state_q == ST_RECV),
    .tc_o   (timeout)
  );

  // TX handshake: a byte moves only on a cycle where tx_valid && tx_ready;
  // while tx_ready is low, tx_valid and tx_byte hold their values.
  assign tx_byte   = tx_q[TX_W-1 -: DATA_SIZE];
  assign tx_valid  = (state_q == ST_SEND);
  assign op_start  = (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign op_word   = op_word_q;
  assign rx_drop   = rx_drop_q;
  assign frame_err = frame_err_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rx_cnt_d    = rx_cnt_q;
    op_word_d   = op_word_q;
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    rx_drop_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          shift_d  = SH_W'(rx_byte);
          rx_cnt_d = RXC_W'(1);
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
          csum_d   = rx_byte;
`endif
          if (RX_FRAME == 1) begin
            state_d   = ST_START;
            op_word_d = shift_d[RX_WIDTH-1:0];
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        // A byte landing on the timeout cycle is lost with the frame.
        if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          shift_d     = '0;
          rx_cnt_d    = '0;
        end else if (rx_valid) begin
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
          if (rx_cnt_q == RXC_W'(RX_COUNT)) begin
            rx_cnt_d = '0;
            if (rx_byte == csum_q) begin
              state_d   = ST_START;
              op_word_d = shift_q[RX_WIDTH-1:0];
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_IDLE;
              shift_d     = '0;
            end
          end else begin
            shift_d  = (shift_q << DATA_SIZE) | SH_W'(rx_byte);
            csum_d   = csum_q ^ rx_byte;
            rx_cnt_d = rx_cnt_q + RXC_W'(1);
          end
`else
          shift_d  = (shift_q << DATA_SIZE) | SH_W'(rx_byte);
          rx_cnt_d = rx_cnt_q + RXC_W'(1);
          if (rx_cnt_d == RXC_W'(RX_FRAME)) begin
            state_d   = ST_START;
            op_word_d = shift_d[RX_WIDTH-1:0];
          end
`endif
        end
      end
      ST_START: begin
        rx_drop_d = rx_valid;
        rx_cnt_d  = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        rx_drop_d = rx_valid;
        if (op_done) begin
          tx_d     = tx_load;
          tx_cnt_d = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        rx_drop_d = rx_valid;
        if (tx_ready) begin
          tx_d     = tx_q << DATA_SIZE;
          tx_cnt_d = tx_cnt_q + TXC_W'(1);
          if (tx_cnt_q == TXC_W'(TX_FRAME - 1)) begin
            tx_cnt_d = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      rx_cnt_q    <= '0;
      op_word_q   <= '0;
      tx_q        <= '0;
      tx_cnt_q    <= '0;
      rx_drop_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rx_cnt_q    <= rx_cnt_d;
      op_word_q   <= op_word_d;
      tx_q        <= tx_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_drop_q   <= rx_drop_d;
      frame_err_q <= frame_err_d;
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_packet_bridge.sv
// Self-checking bench for uart_packet_bridge: table vectors, corner-case
// sequences and randomized frames against a byte-level reference model.
`timescale 1ns/1ps
module tb_uart_packet_bridge;

  localparam int DW  = 8;
  localparam int RXW = 65;
  localparam int TXW = 38;
  localparam int TMO = 100;
  localparam int RXC = 9;
  localparam int TXC = 5;
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
  localparam int TXF = TXC + 1;
`else
  localparam int TXF = TXC;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  rx_byte = '0;
  logic           rx_valid = 1'b0;
  logic [DW-1:0]  tx_byte;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic [RXW-1:0] op_word;
  logic           op_start;
  logic           op_done = 1'b0;
  logic [TXW-1:0] op_result = '0;
  logic           busy;
  logic           rx_drop;
  logic           frame_err;
  logic [2:0]     state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_packet_bridge #(
    .DATA_SIZE(DW), .RX_WIDTH(RXW), .TX_WIDTH(TXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .op_word(op_word), .op_start(op_start), .op_done(op_done),
    .op_result(op_result), .busy(busy), .rx_drop(rx_drop),
    .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int op_start_cnt = 0;
  int tx_acc_cnt = 0;
  int drop_cnt = 0;
  int ferr_cnt = 0;
  int exp_drop = 0;
  int exp_ferr = 0;
  logic [RXW-1:0] exp_op_q[$];
  logic [DW-1:0]  exp_tx_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (op_start) begin
        op_start_cnt++;
        if (exp_op_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL op_start_unexpected op_word=%0h expected no start", op_word);
        end else begin
          chk("op_word", op_word, exp_op_q.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        tx_acc_cnt++;
        if (exp_tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected tx_byte=%0h expected no byte", tx_byte);
        end else begin
          chk("tx_byte", tx_byte, exp_tx_q.pop_front());
        end
      end
      if (rx_drop) drop_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  // Sends the 9 payload bytes first-byte-first with random gaps between them.
  task automatic send_frame(input logic [71:0] bytes, input int gap_max, input bit bad_csum);
    logic [DW-1:0] cs = '0;
    logic [DW-1:0] b;
    for (int i = RXC - 1; i >= 0; i--) begin
      b = bytes[i*DW +: DW];
      cs = cs ^ b;
      send_byte(b);
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
      repeat ($urandom_range(0, gap_max)) step();
`else
      if (i != 0) repeat ($urandom_range(0, gap_max)) step();
`endif
    end
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
    send_byte(bad_csum ? 8'hFF : cs);
`else
    if (bad_csum) cs = '0;
`endif
  endtask

  task automatic wait_op_start(input int prev);
    int n = 0;
    while (op_start_cnt == prev && n < 50) begin
      step();
      n++;
    end
    chk("op_start_count", op_start_cnt - prev, 1);
  endtask

  // Expected TX stream: result bytes MSB first (pad bits lead), then XOR.
  task automatic finish_op(input logic [TXW-1:0] res, input logic [39:0] exp_bytes, input int delay);
    logic [DW-1:0] x = '0;
    repeat (delay) step();
    for (int i = TXC - 1; i >= 0; i--) begin
      exp_tx_q.push_back(exp_bytes[i*DW +: DW]);
      x = x ^ exp_bytes[i*DW +: DW];
    end
`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
    exp_tx_q.push_back(x);
`endif
    op_result = res;
    op_done   = 1'b1;
    step();
    op_done   = 1'b0;
    op_result = TXW'({$urandom, $urandom});
    chk("tx_valid_latency", tx_valid, 1'b1);
  endtask

  task automatic drain(input bit rnd);
    for (int i = 0; i < 200 && busy; i++) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    tx_ready = 1'b0;
    chk("drain_idle", busy, 1'b0);
  endtask

  typedef struct packed {
    logic [71:0]    bytes;
    logic [RXW-1:0] word;
    logic [TXW-1:0] res;
    logic [39:0]    txb;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int ps, pf, pd, pa, n;
    logic [71:0]    rb;
    logic [TXW-1:0] rr;

    tbl[0] = '{72'h01_3F80_0000_4000_0000, 65'h1_3F80_0000_4000_0000,
               38'h00_4000_0000, 40'h00_4000_0000};
    tbl[1] = '{72'h00_FFFF_FFFF_0000_0001, 65'h0_FFFF_FFFF_0000_0001,
               38'h3F_FFFF_FFFF, 40'h3F_FFFF_FFFF};
    tbl[2] = '{72'hFF_1234_5678_9ABC_DEF0, 65'h1_1234_5678_9ABC_DEF0,
               38'h12_3456_789A, 40'h12_3456_789A};
    tbl[3] = '{72'h80_0000_0000_0000_0000, 65'h0,
               38'h20_0000_0001, 40'h20_0000_0001};

    step();
    step();
    rst = 1'b0;
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_op_start", op_start, 1'b0);
    chk("reset_op_word", op_word, '0);
    chk("reset_rx_drop", rx_drop, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_state", state_dbg, uart_pkg::ST_IDLE);

    // Table-driven frames.
    for (int i = 0; i < 4; i++) begin
      exp_op_q.push_back(tbl[i].word);
      ps = op_start_cnt;
      send_frame(tbl[i].bytes, 2, 1'b0);
      chk("op_start_latency", op_start, 1'b1);
      wait_op_start(ps);
      finish_op(tbl[i].res, tbl[i].txb, i);
      drain(1'b1);
    end

    // Full-rate SEND: one byte per cycle, then idle.
    exp_op_q.push_back(tbl[0].word);
    ps = op_start_cnt;
    send_frame(tbl[0].bytes, 0, 1'b0);
    wait_op_start(ps);
    tx_ready = 1'b1;
    pa = tx_acc_cnt;
    finish_op(tbl[0].res, tbl[0].txb, 0);
    repeat (TXF - 1) step();
    chk("full_rate_busy_last", busy, 1'b1);
    step();
    chk("full_rate_busy_done", busy, 1'b0);
    chk("full_rate_count", tx_acc_cnt - pa, TXF);
    tx_ready = 1'b0;

    // Back-pressure mid-SEND.
    exp_op_q.push_back(tbl[2].word);
    ps = op_start_cnt;
    send_frame(tbl[2].bytes, 1, 1'b0);
    wait_op_start(ps);
    tx_ready = 1'b1;
    finish_op(tbl[2].res, tbl[2].txb, 1);
    step();
    tx_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_tx_valid", tx_valid, 1'b1);
      chk("stall_tx_byte", tx_byte, exp_tx_q[0]);
    end
    drain(1'b0);

    // Stray byte while waiting on the operator.
    exp_op_q.push_back(tbl[1].word);
    ps = op_start_cnt;
    send_frame(tbl[1].bytes, 1, 1'b0);
    wait_op_start(ps);
    pd = drop_cnt;
    send_byte(8'hA5);
    exp_drop++;
    step();
    chk("wait_rx_drop", drop_cnt - pd, 1);
    chk("wait_still_busy", busy, 1'b1);
    finish_op(tbl[1].res, tbl[1].txb, 2);
    drain(1'b1);

    // Inter-byte timeout after 4 bytes.
    pf = ferr_cnt;
    ps = op_start_cnt;
    for (int i = RXC - 1; i >= RXC - 4; i--) send_byte(tbl[0].bytes[i*DW +: DW]);
    n = 0;
    while (ferr_cnt == pf && n < TMO + 20) begin
      step();
      n++;
    end
    exp_ferr++;
    chk("timeout_window", (n >= TMO) && (n <= TMO + 2), 1'b1);
    chk("timeout_frame_err", ferr_cnt - pf, 1);
    chk("timeout_no_start", op_start_cnt - ps, 0);
    chk("timeout_idle", busy, 1'b0);
    exp_op_q.push_back(tbl[0].word);
    send_frame(tbl[0].bytes, 0, 1'b0);
    wait_op_start(ps);
    finish_op(tbl[0].res, tbl[0].txb, 0);
    drain(1'b1);

    // Reset while the third TX byte is on offer.
    exp_op_q.push_back(tbl[2].word);
    ps = op_start_cnt;
    send_frame(tbl[2].bytes, 0, 1'b0);
    wait_op_start(ps);
    tx_ready = 1'b1;
    pa = tx_acc_cnt;
    finish_op(tbl[2].res, tbl[2].txb, 0);
    n = 0;
    while (tx_acc_cnt - pa < 2 && n < 20) begin
      step();
      n++;
    end
    chk("pre_reset_accepts", tx_acc_cnt - pa, 2);
    rst = 1'b1;
    tx_ready = 1'b0;
    step();
    chk("reset_mid_send_tx_valid", tx_valid, 1'b0);
    chk("reset_mid_send_busy", busy, 1'b0);
    chk("reset_mid_send_op_word", op_word, '0);
    rst = 1'b0;
    exp_tx_q.delete();
    exp_op_q.push_back(tbl[1].word);
    ps = op_start_cnt;
    send_frame(tbl[1].bytes, 1, 1'b0);
    wait_op_start(ps);
    finish_op(tbl[1].res, tbl[1].txb, 1);
    drain(1'b1);

`ifdef UART_PACKET_BRIDGE_CHECKSUM_EN
    // Bad checksum is rejected, good one accepted.
    pf = ferr_cnt;
    ps = op_start_cnt;
    send_frame(tbl[0].bytes, 0, 1'b1);
    step();
    step();
    exp_ferr++;
    chk("csum_bad_frame_err", ferr_cnt - pf, 1);
    chk("csum_bad_no_start", op_start_cnt - ps, 0);
    chk("csum_bad_idle", busy, 1'b0);
    exp_op_q.push_back(tbl[0].word);
    send_frame(tbl[0].bytes, 0, 1'b0);
    chk("csum_good_start", op_start, 1'b1);
    wait_op_start(ps);
    finish_op(tbl[0].res, tbl[0].txb, 0);
    drain(1'b1);
`endif

    // Randomized frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      rb = {8'($urandom), $urandom, $urandom};
      rr = TXW'({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        op_result = TXW'({$urandom, $urandom});
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("idle_op_done_ignored", busy, 1'b0);
      end
      exp_op_q.push_back(rb[RXW-1:0]);
      ps = op_start_cnt;
      send_frame(rb, 3, 1'b0);
      chk("op_start_latency", op_start, 1'b1);
      wait_op_start(ps);
      if ($urandom_range(0, 2) == 0) begin
        send_byte(8'($urandom));
        exp_drop++;
      end
      finish_op(rr, 40'(rr), $urandom_range(0, 4));
      drain(1'b1);
    end

    step();
    chk("final_op_queue_empty", exp_op_q.size(), 0);
    chk("final_tx_queue_empty", exp_tx_q.size(), 0);
    chk("final_drop_count", drop_cnt, exp_drop);
    chk("final_frame_err_count", ferr_cnt, exp_ferr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
